vwidth_cvt_unit: RTL and testbench
==================================

Name: vwidth_cvt_unit

Overview:
- Streaming vector width-conversion stage between the vector register read port and the vector ALU writeback.
- Performs CVT_WIDE (SEW to 2*SEW sign/zero extension), CVT_NARROW (2*SEW to SEW truncation) and CVT_NONE pass-through on whole VLEN-bit register beats.
- Widening produces two output beats per input. Narrowing consumes two input beats per output.
- Parametrised in VLEN/ELEN, replacing the fixed 256-bit vector_t view with valid/ready handshakes on both sides.

Parameters:
- VLEN, 256, vector register width in bits; power of 2, at least 2*ELEN.
- ELEN, 64, maximum element width in bits; SEW above ELEN is illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; highest priority after reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_op  in  2  width_cvt_t: CVT_NONE=0, CVT_WIDE=1, CVT_NARROW=2; 3 is illegal.
- in_sew  in  3  sew_t. Source SEW for WIDE, destination SEW for NARROW, ignored for NONE.
- in_signed  in  1  WIDE: 1 = sign-extend, 0 = zero-extend.
- in_data  in  VLEN  source register beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  output beat consumed when out_valid && out_ready.
- out_data  out  VLEN  result beat.
- out_last  out  1  final beat of the current operation.
- out_err  out  1  illegal op/SEW; qualified by out_valid.

Behaviour:
- Reset (async): state=IDLE, out_valid=0, out_data=0, out_last=0, out_err=0, holding registers=0. in_ready is 0 while rst is asserted.
- Output register is single-entry. It is free when !out_valid || out_ready.
- in_ready = (state != WIDE_HI) && free && !flush.
- Latency: beat accepted at edge t drives out_valid from t+1. NONE streams at 1 beat/cycle.
- States: IDLE, WIDE_HI, NARROW_WAIT.
- Parameters per op: s = element width (8 << in_sew); N = VLEN/s for WIDE; M = VLEN/(2s) for NARROW.
- CVT_NONE, accepted in IDLE:
  - out_data = in_data, out_last=1, out_err=0.
- CVT_WIDE, legal when in_sew < log2(ELEN/8):
  - Beat 0: element j = ext(src[j]) at width 2s, for j in 0..N/2-1; out_last=0.
  - Latch src upper half (VLEN/2 bits) and in_signed; go to WIDE_HI.
  - In WIDE_HI, when the output register is free: load beat 1 with element j = ext(src[N/2+j]); out_last=1; go to IDLE.
  - A beat-0 handshake at edge t loads beat 1 at the same edge t. No bubble.
- CVT_NARROW, legal when 2s <= ELEN:
  - First accepted beat (IDLE): latch low half = trunc_s(in[k]) for k in 0..M-1. Latch sew. Go to NARROW_WAIT. No output is produced.
  - Second accepted beat (NARROW_WAIT): in_op, in_sew and in_signed are ignored. High half = trunc_s(in[k]). Emit out_data = {high, low}, out_last=1, go to IDLE.
- Illegal cases: in_op=3; in_sew[2]=1; WIDE with s=ELEN; NARROW with s=ELEN.
  - One output beat: out_data=0, out_err=1, out_last=1.
  - State stays IDLE.
  - Applies only to beats accepted in IDLE.
- Flush:
  - Next edge: state=IDLE, out_valid=0, out_last=0, out_err=0, pending half discarded.
  - Input is not accepted in the flush cycle.
- Output stability: while out_valid && !out_ready, out_data/out_last/out_err are held stable.
- Reset mid-operation aborts immediately with no residual beat.

Test Plan:
- WIDE, SEW8, in_signed=1, VLEN=256; i8[0]=0x80, i8[16]=0x7F. Expect:
  - beat0 i16[0]=0xFF80, out_last=0.
  - beat1 i16[0]=0x007F, out_last=1.
  - Repeat with in_signed=0: beat0 i16[0]=0x0080.
- NARROW, SEW16; beat A i32[k]=0x12340000+k, beat B i32[k]=0xABCD0100+k, k=0..7. Expect one beat: i16[k]=k, i16[8+k]=0x0100+k, out_last=1.
- Backpressure: WIDE SEW32 with out_ready=0 for 5 cycles after beat0. Expect:
  - beat0 held bit-stable, in_ready=0.
  - On out_ready=1: beat1 on the next cycle, exactly 2 beats total.
- Illegal: WIDE SEW64, then in_op=3. Expect two beats, each out_data=0, out_err=1, out_last=1; state IDLE.
- Flush in NARROW_WAIT, then NONE with in_data=0xA5 repeated. Expect a single output beat 0xA5..A5, with no trace of the discarded low half.
- Streaming: 8 back-to-back NONE beats with out_ready=1. Expect 8 outputs on consecutive cycles, latency 1. Assert rst mid-WIDE: out_valid drops immediately, no beat1 appears.

Source files
------------

// File: rtl/vwidth_cvt_unit.sv
// vwidth_cvt_unit: streaming vector width converter.
// Widens SEW elements to 2*SEW (two output beats per input beat), narrows
// 2*SEW elements to SEW (two input beats per output beat), or passes a beat
// through unchanged. Both sides use valid/ready handshakes. The output is a
// single registered entry.
module vwidth_cvt_unit #(
    parameter int VLEN = 256,
    parameter int ELEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [2:0]      in_sew,
    input  logic            in_signed,
    input  logic [VLEN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VLEN-1:0] out_data,
    output logic            out_last,
    output logic            out_err
);

    localparam int HALF = VLEN / 2;
    // Number of SEW codes usable as a source (WIDE) or destination (NARROW)
    // element width: every s with 2*s <= ELEN, i.e. codes 0 .. NUM_SEW-1.
    localparam int NUM_SEW = $clog2(ELEN / 8);

    localparam logic [1:0] CVT_NONE   = 2'd0;
    localparam logic [1:0] CVT_WIDE   = 2'd1;
    localparam logic [1:0] CVT_NARROW = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WIDE_HI     = 2'd1,
        ST_NARROW_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [VLEN-1:0]   out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              out_err_q, out_err_d;
    // Pending half: upper source half for WIDE, narrowed low half for NARROW.
    logic [HALF-1:0]   hold_q, hold_d;
    logic              signed_q, signed_d;
    logic [2:0]        sew_q, sew_d;

    logic              out_free;
    logic              in_fire;
    logic              sew_legal;

    logic [HALF-1:0]   wide_src;
    logic              wide_sgn;
    logic [2:0]        wide_sew;
    logic [2:0]        narrow_sew;

    logic [NUM_SEW-1:0][VLEN-1:0] wide_res;
    logic [NUM_SEW-1:0][HALF-1:0] narrow_res;
    logic [VLEN-1:0]   wide_sel;
    logic [HALF-1:0]   narrow_sel;

    // Output register can take a new beat when empty or being drained now.
    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = !rst && (state_q != ST_WIDE_HI) && out_free && !flush;
    assign in_fire   = in_valid && in_ready;
    // SEW codes with bit 2 set are never legal; the rest must leave room
    // for a 2*SEW element within ELEN.
    assign sew_legal = !in_sew[2] && (int'(in_sew) < NUM_SEW);

    // Beat 1 of a widen reuses the same extender on the latched upper half.
    assign wide_src   = (state_q == ST_WIDE_HI) ? hold_q   : in_data[HALF-1:0];
    assign wide_sgn   = (state_q == ST_WIDE_HI) ? signed_q : in_signed;
    assign wide_sew   = (state_q == ST_WIDE_HI) ? sew_q    : in_sew;
    // The second narrow beat uses the SEW latched with the first one.
    assign narrow_sew = (state_q == ST_NARROW_WAIT) ? sew_q : in_sew;

    // One extender and one truncator per legal element width.
    generate
        for (genvar gi = 0; gi < NUM_SEW; gi++) begin : g_sew
            localparam int S = 8 << gi;
            for (genvar gj = 0; gj < HALF / S; gj++) begin : g_wide
                assign wide_res[gi][gj*2*S +: 2*S] =
                    {{S{wide_sgn & wide_src[gj*S + S - 1]}}, wide_src[gj*S +: S]};
            end
            for (genvar gj = 0; gj < VLEN / (2 * S); gj++) begin : g_narrow
                assign narrow_res[gi][gj*S +: S] = in_data[gj*2*S +: S];
            end
        end
    endgenerate

    // Pick the converter output matching the active element width.
    always_comb begin
        wide_sel   = '0;
        narrow_sel = '0;
        for (int i = 0; i < NUM_SEW; i++) begin
            if (wide_sew == 3'(i)) begin
                wide_sel = wide_res[i];
            end
            if (narrow_sew == 3'(i)) begin
                narrow_sel = narrow_res[i];
            end
        end
    end

    // Next-state and output-register update.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        hold_d      = hold_q;
        signed_d    = signed_q;
        sew_d       = sew_q;

        // A consumed beat empties the register unless reloaded below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_err_d   = 1'b0;
            hold_d      = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_fire) begin
                        if (in_op == CVT_NONE) begin
                            out_valid_d = 1'b1;
                            out_data_d  = in_data;
                            out_last_d  = 1'b1;
                            out_err_d   = 1'b0;
                        end else if (in_op == CVT_WIDE && sew_legal) begin
                            out_valid_d = 1'b1;
                            out_data_d  = wide_sel;
                            out_last_d  = 1'b0;
                            out_err_d   = 1'b0;
                            hold_d      = in_data[VLEN-1:HALF];
                            signed_d    = in_signed;
                            sew_d       = in_sew;
                            state_d     = ST_WIDE_HI;
                        end else if (in_op == CVT_NARROW && sew_legal) begin
                            // First half only; nothing is emitted yet.
                            hold_d  = narrow_sel;
                            sew_d   = in_sew;
                            state_d = ST_NARROW_WAIT;
                        end else begin
                            out_valid_d = 1'b1;
                            out_data_d  = '0;
                            out_last_d  = 1'b1;
                            out_err_d   = 1'b1;
                        end
                    end
                end
                ST_WIDE_HI: begin
                    // Beat 1 loads as soon as beat 0 leaves, with no bubble.
                    if (out_free) begin
                        out_valid_d = 1'b1;
                        out_data_d  = wide_sel;
                        out_last_d  = 1'b1;
                        out_err_d   = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                ST_NARROW_WAIT: begin
                    // Op, SEW and sign of the second beat are don't-care.
                    if (in_fire) begin
                        out_valid_d = 1'b1;
                        out_data_d  = {narrow_sel, hold_q};
                        out_last_d  = 1'b1;
                        out_err_d   = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // All state and output registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            hold_q      <= '0;
            signed_q    <= 1'b0;
            sew_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            hold_q      <= hold_d;
            signed_q    <= signed_d;
            sew_q       <= sew_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_vwidth_cvt_unit.sv
// Testbench for vwidth_cvt_unit: scoreboard of expected beats checked by a
// monitor at each output handshake, plus per-scenario inline checks.
module tb_vwidth_cvt_unit;

    localparam int VLEN = 256;
    localparam int ELEN = 64;

    localparam logic [1:0] OP_NONE   = 2'd0;
    localparam logic [1:0] OP_WIDE   = 2'd1;
    localparam logic [1:0] OP_NARROW = 2'd2;
    localparam logic [1:0] OP_BAD    = 2'd3;

    typedef struct {
        logic [VLEN-1:0] data;
        logic            last;
        logic            err;
        int              cyc;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_op = 2'd0;
    logic [2:0]      in_sew = 3'd0;
    logic            in_signed = 1'b0;
    logic [VLEN-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [VLEN-1:0] out_data;
    logic            out_last;
    logic            out_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    beat_t exp_q[$];
    beat_t act_q[$];
    beat_t mon_a;
    beat_t mon_e;

    vwidth_cvt_unit #(.VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_sew    (in_sew),
        .in_signed (in_signed),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output handshake is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_a.data = out_data;
            mon_a.last = out_last;
            mon_a.err  = out_err;
            mon_a.cyc  = cyc;
            act_q.push_back(mon_a);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat data=%h last=%b err=%b", out_data, out_last, out_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data || out_last !== mon_e.last || out_err !== mon_e.err) begin
                    failures++;
                    $display("FAIL beat got data=%h last=%b err=%b want data=%h last=%b err=%b",
                             out_data, out_last, out_err, mon_e.data, mon_e.last, mon_e.err);
                end
            end
            $display("beat data=%h last=%b err=%b cyc=%0d", out_data, out_last, out_err, cyc);
        end
    end

    // Reference widening: half 0 or 1 of src, sign/zero extended to 2s.
    function automatic logic [VLEN-1:0] m_wide(input logic [VLEN-1:0] src, input int sew,
                                               input logic sgn, input logic hi);
        logic [VLEN-1:0] r;
        int s, n, base, idx;
        r = '0;
        s = 8 << sew;
        n = VLEN / (2 * s);
        base = hi ? n : 0;
        for (int j = 0; j < n; j++) begin
            for (int b = 0; b < 2 * s; b++) begin
                idx = (base + j) * s + ((b < s) ? b : s - 1);
                r[j*2*s + b] = (b < s) ? src[idx] : (sgn & src[idx]);
            end
        end
        return r;
    endfunction

    // Reference narrowing: keep low s bits of each 2s-bit element.
    function automatic logic [VLEN/2-1:0] m_narrow(input logic [VLEN-1:0] src, input int sew);
        logic [VLEN/2-1:0] r;
        int s;
        r = '0;
        s = 8 << sew;
        for (int k = 0; k < VLEN / (2 * s); k++) begin
            for (int b = 0; b < s; b++) begin
                r[k*s + b] = src[k*2*s + b];
            end
        end
        return r;
    endfunction

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_exp(input logic [VLEN-1:0] d, input logic last, input logic err);
        beat_t b;
        b.data = d;
        b.last = last;
        b.err  = err;
        b.cyc  = 0;
        exp_q.push_back(b);
    endtask

    // Present one input beat (called at posedge+1) until it is accepted.
    task automatic send(input logic [1:0] op, input logic [2:0] sew, input logic sgn,
                        input logic [VLEN-1:0] d);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_op     = op;
        in_sew    = sew;
        in_signed = sgn;
        in_data   = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags valid=%b last=%b err=%b want 000", out_valid, out_last, out_err);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h want 0", out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_wide(input logic sgn);
        logic [VLEN-1:0] d;
        logic [15:0] want0;
        d = rand_vec();
        d[7:0]     = 8'h80;
        d[135:128] = 8'h7F;
        want0 = sgn ? 16'hFF80 : 16'h0080;
        act_q.delete();
        out_ready = 1'b1;
        push_exp(m_wide(d, 0, sgn, 1'b0), 1'b0, 1'b0);
        push_exp(m_wide(d, 0, sgn, 1'b1), 1'b1, 1'b0);
        send(OP_WIDE, 3'd0, sgn, d);
        wait_drain("wide");
        checks++;
        if (act_q.size() != 2) begin
            failures++;
            $display("FAIL wide_count got=%0d want 2", act_q.size());
        end else begin
            checks++;
            if (act_q[0].data[15:0] !== want0 || act_q[0].last !== 1'b0) begin
                failures++;
                $display("FAIL wide_beat0 got=%h last=%b want %h last=0",
                         act_q[0].data[15:0], act_q[0].last, want0);
            end
            checks++;
            if (act_q[1].data[15:0] !== 16'h007F || act_q[1].last !== 1'b1) begin
                failures++;
                $display("FAIL wide_beat1 got=%h last=%b want 007f last=1",
                         act_q[1].data[15:0], act_q[1].last);
            end
        end
        $display("test_wide signed=%b done", sgn);
    endtask

    task automatic test_narrow();
        logic [VLEN-1:0] a, b;
        for (int k = 0; k < 8; k++) begin
            a[k*32 +: 32] = 32'h12340000 + k;
            b[k*32 +: 32] = 32'hABCD0100 + k;
        end
        act_q.delete();
        out_ready = 1'b1;
        push_exp({m_narrow(b, 1), m_narrow(a, 1)}, 1'b1, 1'b0);
        send(OP_NARROW, 3'd1, 1'b0, a);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL narrow_first_beat out_valid=%b want 0", out_valid);
        end
        // Second beat's op/sew/sign must be ignored.
        send(OP_BAD, 3'd7, 1'b1, b);
        wait_drain("narrow");
        checks++;
        if (act_q.size() != 1) begin
            failures++;
            $display("FAIL narrow_count got=%0d want 1", act_q.size());
        end else begin
            checks++;
            if (act_q[0].data[15:0] !== 16'h0000 || act_q[0].data[127:112] !== 16'h0007
                || act_q[0].data[143:128] !== 16'h0100 || act_q[0].data[255:240] !== 16'h0107) begin
                failures++;
                $display("FAIL narrow_fields got=%h want i16[k]=k i16[8+k]=0100+k", act_q[0].data);
            end
        end
        $display("test_narrow done");
    endtask

    task automatic test_backpressure();
        logic [VLEN-1:0] d, snap;
        d = rand_vec();
        act_q.delete();
        out_ready = 1'b0;
        push_exp(m_wide(d, 2, 1'b1, 1'b0), 1'b0, 1'b0);
        push_exp(m_wide(d, 2, 1'b1, 1'b1), 1'b1, 1'b0);
        send(OP_WIDE, 3'd2, 1'b1, d);
        snap = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== snap || out_last !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d valid=%b last=%b in_ready=%b stable=%b want 1 0 0 1",
                         i, out_valid, out_last, in_ready, out_data === snap);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain("bp");
        checks++;
        if (act_q.size() != 2) begin
            failures++;
            $display("FAIL bp_count got=%0d want 2", act_q.size());
        end else begin
            checks++;
            if (act_q[1].cyc !== act_q[0].cyc + 1) begin
                failures++;
                $display("FAIL bp_gap got=%0d want 1", act_q[1].cyc - act_q[0].cyc);
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_illegal();
        logic [VLEN-1:0] d;
        d = rand_vec();
        act_q.delete();
        out_ready = 1'b1;
        push_exp('0, 1'b1, 1'b1);
        push_exp('0, 1'b1, 1'b1);
        push_exp('0, 1'b1, 1'b1);
        push_exp(d, 1'b1, 1'b0);
        send(OP_WIDE, 3'd3, 1'b0, rand_vec());
        send(OP_BAD, 3'd0, 1'b0, rand_vec());
        send(OP_NARROW, 3'd3, 1'b0, rand_vec());
        // A pass-through right after shows the unit stayed idle.
        send(OP_NONE, 3'd5, 1'b0, d);
        wait_drain("illegal");
        checks++;
        if (act_q.size() != 4) begin
            failures++;
            $display("FAIL illegal_count got=%0d want 4", act_q.size());
        end
        $display("test_illegal done");
    endtask

    task automatic test_flush();
        logic [VLEN-1:0] a5;
        a5 = {(VLEN/8){8'hA5}};
        act_q.delete();
        out_ready = 1'b1;
        send(OP_NARROW, 3'd0, 1'b0, {VLEN{1'b1}});
        push_exp(a5, 1'b1, 1'b0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_op     = OP_NONE;
        in_data   = a5;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_in_ready got=%b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        send(OP_NONE, 3'd0, 1'b0, a5);
        wait_drain("flush");
        checks++;
        if (act_q.size() != 1) begin
            failures++;
            $display("FAIL flush_count got=%0d want 1", act_q.size());
        end
        $display("test_flush done");
    endtask

    task automatic test_back_to_back();
        logic [VLEN-1:0] d [8];
        int acc_cyc;
        acc_cyc = 0;
        act_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d[i] = rand_vec();
            push_exp(d[i], 1'b1, 1'b0);
        end
        in_valid = 1'b1;
        in_op    = OP_NONE;
        for (int i = 0; i < 8; i++) begin
            in_data = d[i];
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_in_ready beat=%0d got=%b want 1", i, in_ready);
            end
            if (i == 0) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_drain("stream");
        checks++;
        if (act_q.size() != 8) begin
            failures++;
            $display("FAIL stream_count got=%0d want 8", act_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (act_q[i].cyc != acc_cyc + 1 + i) begin
                    failures++;
                    $display("FAIL stream_timing beat=%0d got=%0d want %0d", i, act_q[i].cyc, acc_cyc + 1 + i);
                end
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        act_q.delete();
        out_ready = 1'b0;
        send(OP_WIDE, 3'd0, 1'b1, rand_vec());
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_beat0 out_valid=%b want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (act_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_residual beats=%0d out_valid=%b want 0 0", act_q.size(), out_valid);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_wide(1'b1);
        test_wide(1'b0);
        test_narrow();
        test_backpressure();
        test_illegal();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
